// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for an external ALU.
// Accepts one op at a time, drives the ALU, and returns the result with a valid/ready response.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [6:0]  req0_funct7,
  input  logic [2:0]  req0_funct3,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [6:0]  req1_funct7,
  input  logic [2:0]  req1_funct3,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [6:0]  alu_funct7,
  output logic [2:0]  alu_funct3,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  state_e             state_q, state_d;
  op_t                op_q, op_d;
  logic               last_q, last_d;
  logic               gnt_q, gnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic [FLAGS_W-1:0] rsp_flags_q, rsp_flags_d;

  logic can_accept;
  logic accept;
  logic pick;
  op_t  pick_op;

  // Round-robin pick: a tie goes to the requester not granted last.
  always_comb begin
    can_accept = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    accept     = can_accept && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) pick = ~last_q;
    else                          pick = req1_valid;
    pick_op = pick ? op_t'{req1_funct7, req1_funct3, req1_a, req1_b}
                   : op_t'{req0_funct7, req0_funct3, req0_a, req0_b};
    req0_ready = accept && !pick;
    req1_ready = accept && pick;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = pick_op;
          last_d  = pick;
          gnt_d   = pick;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_id_d     = gnt_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (accept) begin
            op_d    = pick_op;
            last_d  = pick;
            gnt_d   = pick;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset value of last_q = 1 hands the first tie to requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_funct7 = op_q.funct7;
  assign alu_funct3 = op_q.funct3;
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small add/sub ALU model on the alu_* side.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [6:0]  req0_funct7;
  logic [2:0]  req0_funct3;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [6:0]  req1_funct7;
  logic [2:0]  req1_funct3;
  logic [31:0] req1_a, req1_b;
  logic [6:0]  alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int errors = 0;
  int checks = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct7(req0_funct7),
    .req0_funct3(req0_funct3), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct7(req1_funct7),
    .req1_funct3(req1_funct3), .req1_a(req1_a), .req1_b(req1_b),
    .alu_funct7(alu_funct7), .alu_funct3(alu_funct3), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: SUB for funct7=0100000/funct3=000, ADD otherwise; flags {V,C,N,Z}.
  always_comb begin
    logic [32:0] wide;
    logic        v;
    if (alu_funct7 == 7'b0100000 && alu_funct3 == 3'b000) begin
      wide = {1'b0, alu_a} - {1'b0, alu_b};
      wide[32] = (alu_a >= alu_b);
      v = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
    end else begin
      wide = {1'b0, alu_a} + {1'b0, alu_b};
      v = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
    end
    alu_result = wide[31:0];
    alu_flags  = {v, wide[32], wide[31], (wide[31:0] == 32'd0)};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_funct7 = '0; req0_funct3 = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_funct7 = '0; req1_funct3 = '0; req1_a = '0; req1_b = '0;
    repeat (2) cyc();
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_f7", 32'(alu_funct7), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    cyc();

    // Single add from requester 0: 5 + 7 = 12.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    chk("add_r0_ready", 32'(req0_ready), 32'd1);
    chk("add_r1_ready", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_exec_valid", 32'(rsp_valid), 32'd0);
    cyc();
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_flags", 32'(rsp_flags), 32'd0);
    cyc();
    chk("add_idle_valid", 32'(rsp_valid), 32'd0);

    // Subtract 3 - 3 from requester 1: result 0, Z=1, C=1.
    req1_valid = 1'b1; req1_funct7 = 7'b0100000; req1_funct3 = 3'b000;
    req1_a = 32'd3; req1_b = 32'd3;
    #1;
    chk("sub_r1_ready", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("sub_result", rsp_result, 32'd0);
    chk("sub_flags", 32'(rsp_flags), 32'h5);
    chk("sub_id", 32'(rsp_id), 32'd1);
    cyc();

    // Requester 1 alone, back-to-back, even though it was granted last.
    req1_funct7 = '0; req1_valid = 1'b1; req1_a = 32'd10;
    for (int i = 0; i < 3; i++) begin
      req1_b = 32'(20 + i);
      #1;
      chk("solo_r1_accept", 32'(req1_ready), 32'd1);
      cyc();
      req1_b = 32'd999;
      #1;
      chk("solo_r1_exec_ready", 32'(req1_ready), 32'd0);
      chk("solo_alu_b_held", alu_b, 32'(20 + i));
      cyc();
      chk("solo_valid", 32'(rsp_valid), 32'd1);
      chk("solo_result", rsp_result, 32'(30 + i));
      chk("solo_id", 32'(rsp_id), 32'd1);
    end
    req1_valid = 1'b0;
    cyc();
    chk("solo_idle_valid", 32'(rsp_valid), 32'd0);

    // Backpressure: response held for 5 cycles, requester 1 waits, then taken on the handshake.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
    #1;
    chk("bp_r0_accept", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200;
    #1;
    chk("bp_exec_r1_ready", 32'(req1_ready), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_r1_ready", 32'(req1_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, 32'd3);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_alu_a", alu_a, 32'd1);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_r1_accept", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    chk("bp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("bp_alu_a_r1", alu_a, 32'd100);
    cyc();
    chk("bp_result_r1", rsp_result, 32'd300);
    chk("bp_id_r1", 32'(rsp_id), 32'd1);
    cyc();

    // Reset while in EXEC discards the op and restores the tie pointer.
    req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd60;
    cyc();
    req0_valid = 1'b0;
    rst = 1'b1;
    cyc();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("exec_rst_ready0", 32'(req0_ready), 32'd0);
    chk("exec_rst_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    chk("exec_rst_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rst_result", rsp_result, 32'd0);
    chk("exec_rst_alu_a", alu_a, 32'd0);
    chk("exec_rst_alu_b", alu_b, 32'd0);
    cyc();
    chk("exec_rst_valid_after", 32'(rsp_valid), 32'd0);

    // Tie after reset: grants alternate 0,1,0,1, one response per two cycles.
    req0_a = 32'd1; req0_b = 32'd1; req1_a = 32'd2; req1_b = 32'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_ready0", 32'(req0_ready), 32'((k % 2) == 0));
      chk("tie_ready1", 32'(req1_ready), 32'((k % 2) == 1));
      cyc();
      cyc();
      chk("tie_valid", 32'(rsp_valid), 32'd1);
      chk("tie_id", 32'(rsp_id), 32'(k % 2));
      chk("tie_result", rsp_result, ((k % 2) == 0) ? 32'd2 : 32'd4);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    chk("tie_end_valid", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have, per requester n in {0,1}: reqn_valid input 1; reqn_ready output 1; reqn_funct7 input 7; reqn_funct3 input 3; reqn_a input 32; reqn_b input 32.
REQ-004 SHALL have ALU drive ports: alu_funct7 output 7; alu_funct3 output 3; alu_a output 32; alu_b output 32; alu_result input 32; alu_flags input 4 ({V,C,N,Z}).
REQ-005 SHALL have response ports: rsp_valid output 1; rsp_ready input 1; rsp_id output 1 (granted requester); rsp_result output 32; rsp_flags output 4.

Function
REQ-006 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-007 IDLE: if any reqn_valid, SHALL grant one requester, assert its reqn_ready combinationally that cycle, latch its funct7/funct3/a/b into alu_* registers, and move to EXEC; else stay in IDLE.
REQ-008 reqn_ready SHALL be high only in the acceptance cycle of the granted requester, never for both, never when its reqn_valid is low.
REQ-009 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-010 Last-grant pointer SHALL update only on an accepted request.
REQ-011 EXEC (exactly one cycle): alu_* outputs SHALL be stable; at cycle end SHALL register alu_result into rsp_result, alu_flags into rsp_flags, grant id into rsp_id, set rsp_valid, move to RESP.
REQ-012 RESP: rsp_valid, rsp_id, rsp_result, rsp_flags SHALL hold constant until rsp_valid & rsp_ready.
REQ-013 On RESP handshake with a reqn_valid present, SHALL accept per REQ-007/REQ-009 in that same cycle, clear rsp_valid next cycle, and go to EXEC (back-to-back; one op per 2 cycles).
REQ-014 On RESP handshake with no reqn_valid, SHALL clear rsp_valid and go to IDLE.
REQ-015 In RESP without handshake, SHALL not accept any request (both reqn_ready low).
REQ-016 Latency: accept at edge k -> rsp_valid high after edge k+1 (visible in cycle k+1 post-edge, i.e. 2nd cycle after acceptance cycle).
REQ-017 alu_* outputs SHALL change only on acceptance; held otherwise (no glitching to unrelated requester data).
REQ-018 Requester inputs changing while not granted SHALL have no effect.
REQ-019 No arithmetic performed in this block; result/flags passed through bit-exact, 32-bit.

Reset
REQ-020 On rst high at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_funct7=0, alu_funct3=0, alu_a=0, alu_b=0, last-grant=1 (so requester 0 wins first tie).
REQ-021 reqn_ready SHALL be 0 in any cycle rst is high.
REQ-022 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight op with no rsp_valid produced afterward for it.

Verification
REQ-023 Single op: req0 valid, funct3=000, funct7=0, a=5, b=7, rsp_ready=1 -> req0_ready 1 cycle, rsp_valid next-next cycle with rsp_result=12, rsp_id=0, rsp_flags Z=0.
REQ-024 Tie after reset: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1, one response per 2 cycles.
REQ-025 Backpressure: rsp_ready=0 for 5 cycles while req1 valid -> rsp_* held stable, req1_ready=0 throughout; on rsp_ready=1 req1 accepted same cycle.
REQ-026 Subtract flags: funct7=0100000, funct3=000, a=3, b=3 -> rsp_result=0, rsp_flags Z=1, C=1.
REQ-027 Reset in EXEC: accept req0, assert rst next cycle -> rsp_valid stays 0, all outputs zero, next tie grants req0.
REQ-028 Single requester: only req1 valid repeatedly -> req1 granted every acceptance despite last-grant=1.
